// File: rtl/rr_index_arbiter_pkg.sv
// rr_index_arbiter_pkg: shared constants, state encoding and reset values for the round-robin index arbiter
package rr_index_arbiter_pkg;
  localparam int N = 16;
  localparam int IDXW = 4;
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [IDXW-1:0] PTR_RST = '0;
  localparam logic [IDXW-1:0] IDX_RST = '0;
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: lowest set request at or above ptr, else lowest set request overall
module rr_priority_pick
  import rr_index_arbiter_pkg::*;
(
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic [IDXW-1:0] win_idx,
  output logic            win_any
);
  logic [N-1:0] masked, src;
  always_comb begin
    masked = req & ({N{1'b1}} << ptr);
    src = |masked ? masked : req;
    win_idx = '0;
    for (int i = N - 1; i >= 0; i--) win_idx = src[i] ? IDXW'(i) : win_idx;
    win_any = |req;
  end
endmodule

// File: rtl/rr_index_arbiter.sv
// rr_index_arbiter: 16-way round-robin arbiter offering a registered grant index over valid/ready
module rr_index_arbiter
  import rr_index_arbiter_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            grant_ready,
  output logic            grant_valid,
  output logic [IDXW-1:0] grant_idx,
  output logic            busy
);
  state_t state, state_n;
  logic [IDXW-1:0] ptr, ptr_n, idx_n, pick_ptr, win_idx;
  logic win_any, accept, load;
  assign accept = state == GRANT && grant_ready;
  // the same-cycle re-pick must already see the pointer advanced past the accepted winner
  assign pick_ptr = accept ? grant_idx + IDXW'(1) : ptr;
  assign load = (state == IDLE || accept) && win_any;
  rr_priority_pick u_pick (
    .req     (req),
    .ptr     (pick_ptr),
    .win_idx (win_idx),
    .win_any (win_any)
  );
  always_comb begin
    state_n = load ? GRANT : (accept ? IDLE : state);
    ptr_n = pick_ptr;
    idx_n = load ? win_idx : grant_idx;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= PTR_RST;
      grant_idx <= IDX_RST;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      grant_idx <= idx_n;
    end
  end
  assign grant_valid = state == GRANT;
  assign busy = state == GRANT;
endmodule

// File: tb/tb_rr_index_arbiter.sv
// tb_rr_index_arbiter: scoreboard-driven checks of grant order, backpressure, wrap and reset
module tb_rr_index_arbiter;
  logic clk = 0, rst_n = 0, grant_ready = 0, grant_valid, busy;
  logic [15:0] req = '0;
  logic [3:0] grant_idx;
  int checks = 0, errors = 0;
  int q[$];

  always #5 clk = ~clk;

  rr_index_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant_ready (grant_ready),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .busy        (busy)
  );

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    rst_n = 0; req = 16'hFFFF; grant_ready = 0;
    tick; tick;
    checks++;
    if ({grant_valid, busy, grant_idx} !== 6'h00) begin
      errors++;
      $display("FAIL reset_state: got valid=%0b busy=%0b idx=%0d expected valid=0 busy=0 idx=0", grant_valid, busy, grant_idx);
    end
    rst_n = 1;
    tick;
    checks++;
    if ({grant_valid, busy, grant_idx} !== 6'h30) begin
      errors++;
      $display("FAIL reset_release: got valid=%0b busy=%0b idx=%0d expected valid=1 busy=1 idx=0", grant_valid, busy, grant_idx);
    end
    req = '0; grant_ready = 1;
    tick;
    checks++;
    if (grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_drain: got valid=%0b expected 0", grant_valid);
    end
  endtask

  task automatic test_single;
    req = 16'h0010; grant_ready = 1;
    q.push_back(4); q.push_back(4); q.push_back(4);
    while (q.size() > 0) begin
      tick;
      checks++;
      if ({grant_valid, grant_idx} !== {1'b1, 4'(q[0])}) begin
        errors++;
        $display("FAIL single: got valid=%0b idx=%0d expected valid=1 idx=%0d", grant_valid, grant_idx, q[0]);
      end
      void'(q.pop_front());
    end
    req = '0;
    tick;
    checks++;
    if (grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: got valid=%0b expected 0", grant_valid);
    end
  endtask

  task automatic test_rotation;
    rst_n = 0; grant_ready = 0; req = '0;
    tick;
    rst_n = 1; req = 16'hFFFF; grant_ready = 1;
    for (int i = 0; i < 18; i++) q.push_back(i % 16);
    while (q.size() > 0) begin
      tick;
      checks++;
      if ({grant_valid, grant_idx} !== {1'b1, 4'(q[0])}) begin
        errors++;
        $display("FAIL rotation: got valid=%0b idx=%0d expected valid=1 idx=%0d", grant_valid, grant_idx, q[0]);
      end
      void'(q.pop_front());
    end
    req = '0;
    tick;
  endtask

  task automatic test_backpressure;
    rst_n = 0; grant_ready = 0; req = '0;
    tick;
    rst_n = 1; req = 16'h0201;
    for (int i = 0; i < 4; i++) q.push_back(0);
    q.push_back(9);
    for (int c = 0; c < 5; c++) begin
      tick;
      checks++;
      if ({grant_valid, grant_idx} !== {1'b1, 4'(q[0])}) begin
        errors++;
        $display("FAIL backpressure cycle %0d: got valid=%0b idx=%0d expected valid=1 idx=%0d", c, grant_valid, grant_idx, q[0]);
      end
      void'(q.pop_front());
      if (c == 2) req = 16'h0200;
      grant_ready = c == 3;
    end
    req = '0; grant_ready = 1;
    tick;
    checks++;
    if (grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_idle: got valid=%0b expected 0", grant_valid);
    end
  endtask

  task automatic test_wrap;
    req = 16'h2000; grant_ready = 1;
    q.push_back(13); q.push_back(0); q.push_back(12);
    while (q.size() > 0) begin
      tick;
      checks++;
      if ({grant_valid, grant_idx} !== {1'b1, 4'(q[0])}) begin
        errors++;
        $display("FAIL wrap: got valid=%0b idx=%0d expected valid=1 idx=%0d", grant_valid, grant_idx, q[0]);
      end
      void'(q.pop_front());
      req = 16'h1001;
    end
    req = '0;
    tick;
    checks++;
    if (grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_idle: got valid=%0b expected 0", grant_valid);
    end
  endtask

  task automatic test_mid_reset;
    req = 16'h0080; grant_ready = 0;
    tick;
    checks++;
    if ({grant_valid, grant_idx} !== 5'h17) begin
      errors++;
      $display("FAIL mid_reset_setup: got valid=%0b idx=%0d expected valid=1 idx=7", grant_valid, grant_idx);
    end
    rst_n = 0;
    tick;
    checks++;
    if ({grant_valid, busy, grant_idx} !== 6'h00) begin
      errors++;
      $display("FAIL mid_reset: got valid=%0b busy=%0b idx=%0d expected valid=0 busy=0 idx=0", grant_valid, busy, grant_idx);
    end
    rst_n = 1; req = 16'h8080;
    q.push_back(7); q.push_back(15);
    while (q.size() > 0) begin
      tick;
      checks++;
      if ({grant_valid, grant_idx} !== {1'b1, 4'(q[0])}) begin
        errors++;
        $display("FAIL mid_reset_resume: got valid=%0b idx=%0d expected valid=1 idx=%0d", grant_valid, grant_idx, q[0]);
      end
      void'(q.pop_front());
      grant_ready = 1;
    end
    req = '0;
    tick;
    checks++;
    if (grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_idle: got valid=%0b expected 0", grant_valid);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_rotation;
    test_backpressure;
    test_wrap;
    test_mid_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rr_index_arbiter.md
Name: rr_index_arbiter

Overview:
- 16-requester round-robin arbiter that produces a 4-bit grant index. The index drives the one-hot encoder stage directly downstream, which expands it to a 16-bit select vector.
- Grant is registered and offered with a valid/ready handshake. It is held stable under backpressure.
- Fairness comes from a rotating priority pointer that advances past each accepted winner.

Parameters:
- N, 16, number of requesters; only 16 supported, matching the downstream 16-way encoder
- IDXW, 4, grant index width, equal to log2(N)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- req  input  16  request vector, one bit per requester, level-sensitive
- grant_ready  input  1  downstream accepts the current grant this cycle
- grant_valid  output  1  grant_idx holds a valid offered grant
- grant_idx  output  4  index of granted requester, 0..15
- busy  output  1  high whenever the state is GRANT

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
- Reset values: grant_valid=0, grant_idx=0, busy=0, ptr=0, state=IDLE. Reset overrides every other event in the same cycle, including an accept.
- Pick function: take the lowest set bit of req at index >= ptr. If there is none, take the lowest set bit of req overall. If req==0, there is no winner.
- IDLE state:
  - If req != 0, register the winner into grant_idx, set grant_valid=1 and go to GRANT.
  - Latency is 1 cycle from req sampled to grant_valid high.
  - If req == 0, stay in IDLE.
- GRANT state:
  - grant_valid=1. grant_idx is frozen while grant_ready=0.
  - Accept occurs when grant_valid && grant_ready.
  - On accept, ptr <= (grant_idx+1) mod 16, so 15 wraps to 0.
  - In the same accept cycle, run the pick on the current req using the new pointer value, not the old ptr.
  - If there is a winner, load it and stay in GRANT. This gives back-to-back grants at 1 per cycle.
  - If there is no winner, go to IDLE and set grant_valid=0 on the next cycle.
- Sticky grant: once offered, a grant is not withdrawn even if its req bit drops. Downstream must tolerate a stale grant.
- Changes to req while stalled have no effect on grant_idx until accept.
- Pointer arithmetic is modulo 16 with no carry out. ptr changes only on accept.
- grant_ready while grant_valid=0 is ignored.
- Reset mid-operation: pending grant is dropped with no accept and no pointer update. The pointer restarts at 0.
- No combinational path from req or grant_ready to any output. All outputs are registered.

Decomposition:
- Shared package:
  - constants N=16, IDXW=4
  - state enum {IDLE, GRANT}
  - reset values for ptr and grant_idx
- One sub-module: rr_priority_pick.
  - Purely combinational.
  - Inputs: req[15:0], ptr[3:0]. Outputs: win_idx[3:0], win_any.
  - Implements the masked-then-unmasked lowest-set-bit search.
- The top level holds the state, ptr and output registers plus the handshake logic.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with req=16'hFFFF -> grant_valid=0, grant_idx=0, busy=0. The first cycle after release gives grant_idx=0, grant_valid=1.
- Single request: req=16'h0010, grant_ready=1 -> grant_valid rises one cycle later with grant_idx=4. On accept, ptr=5. With req held and no other requesters, the next grant is idx=4 again.
- Full rotation: req=16'hFFFF, grant_ready=1 constantly -> grant_idx sequences 0,1,2,...,15,0,1 on consecutive cycles with grant_valid continuously high.
- Backpressure and sticky grant:
  - req=16'h0201, grant_ready=0 for 3 cycles -> grant_idx stays 0 throughout.
  - Drop req bit 0 during the stall -> grant_idx still 0.
  - Raise grant_ready for 1 cycle -> next grant_idx=9.
- Wrap-around: after an accepted grant of idx=13 (ptr=14), apply req=16'h1001 -> grant_idx=0, the lowest set bit since none is at >=14. After accept, ptr=1 and the next grant is idx=12.
- Reset mid-operation: grant_valid=1, grant_idx=7, grant_ready=0; pulse rst_n=0 for 1 edge -> grant_valid=0, ptr=0. Then req=16'h8080 -> grant_idx=7, followed by idx=15 after accept.
